conv_pe_sched: RTL and testbench
================================

// Module: conv_pe_sched
// PURPOSE
//  Sequences the conv PE array over one frame. Walks row/col/channel loop indices
//  (chn innermost, then col, then row) and drives c_ctrl_data_run/c_row/c_col/c_chn.
//  Gates each row on the IFM line-buffer ready flags, then drains the PE pipeline
//  before signalling frame completion. Sits between the top controller and conv_pe.
// PARAMETERS
//  W_SIZE        9  width of row/col index and q_width/q_height
//  W_CHANNEL     9  width of channel index and q_channel
//  W_FRAME_SIZE  2  width of q_frame_cnt (frames processed per start)
//  W_DELAY       12 width of drain counter / q_drain
//  IFM_BUF_CNT   4  number of IFM row buffers (ring)
//  W_IFM_BUF     2  log2(IFM_BUF_CNT)
// PORTS
//  clk              in  1              clock
//  rst              in  1              async reset, active-high
//  start            in  1              1-cycle pulse; accepted only in IDLE
//  q_width          in  W_SIZE         columns per row (>=1), sampled on start
//  q_height         in  W_SIZE         rows per frame (>=1), sampled on start
//  q_channel        in  W_CHANNEL      input channels (>=1), sampled on start
//  q_frame_cnt      in  W_FRAME_SIZE   frames-1 per start, sampled on start
//  q_drain          in  W_DELAY        PE pipeline latency in cycles, sampled on start
//  ifm_buf_ready    in  IFM_BUF_CNT    per-buffer "row loaded" flags
//  pe_stall         in  1              PE backpressure; holds indices when high
//  c_ctrl_data_run  out 1              PE input valid for current (row,col,chn)
//  c_row            out W_SIZE         current row index
//  c_col            out W_SIZE         current col index
//  c_chn            out W_CHANNEL      current channel index
//  c_buf_sel        out W_IFM_BUF      IFM buffer feeding current row (= row mod IFM_BUF_CNT)
//  row_done         out 1              1-cycle pulse, last beat of a row issued
//  buf_release      out IFM_BUF_CNT    one-hot 1-cycle pulse, frees c_buf_sel buffer with row_done
//  frame_done       out 1              1-cycle pulse after drain of each frame
//  busy             out 1              high in any state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, indices 0, frame counter 0.
//  - States: IDLE -> (start) WAIT_BUF -> (ifm_buf_ready[c_buf_sel]) RUN
//    RUN -> last beat of row, more rows: WAIT_BUF; last beat of frame: DRAIN
//    DRAIN -> counter reaches q_drain: DONE; DONE (1 cycle, frame_done=1) ->
//    WAIT_BUF with indices 0 if frames remain, else IDLE.
//  - c_ctrl_data_run = (state==RUN) & ~pe_stall, registered outputs (1-cycle from decision).
//  - Beat advances only when c_ctrl_data_run=1: chn++; at q_channel-1 chn=0, col++;
//    at q_width-1 col=0, row++; at q_height-1 end of frame.
//  - Indices stable while stalled or in WAIT_BUF; pe_stall ignored outside RUN.
//  - ifm_buf_ready checked once at WAIT_BUF->RUN; deassertion mid-row is ignored.
//  - c_buf_sel wraps IFM_BUF_CNT-1 -> 0; row wraps to 0 at frame boundary.
//  - row_done and buf_release fire on the cycle the last beat is issued.
//  - DRAIN: q_drain=0 goes straight to DONE next cycle.
//  - start while busy: ignored. Config inputs are sampled only on accepted start.
//  - rst mid-frame: immediate return to IDLE, pulses suppressed, no buf_release.
//  - Counters are width-exact; q_* of 0 are illegal (treated as 1).
// CONFIGURATION
//  CONV_PE_SCHED_PERF_EN defined: adds outputs perf_stall_cyc[31:0] (RUN & pe_stall)
//  and perf_wait_cyc[31:0] (WAIT_BUF cycles), cleared on accepted start, saturating.
//  Not defined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  - controller_params.vh: W_* defaults, IFM_BUFFER_CNT/IFM_BUFFER, state encodings
//    (SCHED_IDLE, SCHED_WAIT_BUF, SCHED_RUN, SCHED_DRAIN, SCHED_DONE).
//  - One sub-module: conv_pe_loop_cnt (nested chn/col/row counter with enable,
//    limits, clear, and last-beat/last-row flags). FSM, buffer select and perf stay in top.
// TESTING
//  1. W=2,H=2,C=3,drain=4, bufs all ready, no stall -> 12 run beats, chn 0..2 per col,
//     row_done at beats 6 and 12, frame_done 5 cycles after last beat, busy->0.
//  2. buf[1]=0 after row 0 -> WAIT_BUF holds, run=0, indices (1,0,0) until buf[1]=1.
//  3. pe_stall pulsed 3 cycles mid-row -> run=0, indices frozen, no beat lost/duplicated.
//  4. H=6 -> c_buf_sel 0,1,2,3,0,1; buf_release one-hot matches each row_done.
//  5. frame_cnt=1 -> two frame_done pulses, indices restart at 0; start while busy ignored.
//  6. rst asserted mid-RUN -> all outputs 0 same cycle, IDLE; next start runs full frame.

Source files
------------

// File: rtl/conv_pe_sched_pkg.sv
// Shared definitions for the conv PE scheduler: default widths, IFM buffer
// ring size and the scheduler state encoding.
package conv_pe_sched_pkg;

  localparam int W_SIZE_DEF       = 9;
  localparam int W_CHANNEL_DEF    = 9;
  localparam int W_FRAME_SIZE_DEF = 2;
  localparam int W_DELAY_DEF      = 12;
  localparam int IFM_BUFFER_CNT   = 4;
  localparam int IFM_BUFFER       = 2;

  typedef enum logic [2:0] {
    SCHED_IDLE     = 3'd0,
    SCHED_WAIT_BUF = 3'd1,
    SCHED_RUN      = 3'd2,
    SCHED_DRAIN    = 3'd3,
    SCHED_DONE     = 3'd4
  } sched_state_t;

endpackage

// File: rtl/conv_pe_loop_cnt.sv
// Nested loop counter: chn innermost, then col, then row. Advances one beat
// per enabled cycle and wraps all indices to 0 after the last beat of a frame.
module conv_pe_loop_cnt
  import conv_pe_sched_pkg::*;
#(
  parameter int W_SIZE    = W_SIZE_DEF,
  parameter int W_CHANNEL = W_CHANNEL_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [W_SIZE-1:0]    row_max,
  input  logic [W_SIZE-1:0]    col_max,
  input  logic [W_CHANNEL-1:0] chn_max,
  output logic [W_SIZE-1:0]    row,
  output logic [W_SIZE-1:0]    col,
  output logic [W_CHANNEL-1:0] chn,
  output logic                 row_end,
  output logic                 frame_end
);

  logic chn_end, col_end, row_last;

  assign chn_end   = (chn == chn_max);
  assign col_end   = (col == col_max);
  assign row_last  = (row == row_max);
  assign row_end   = chn_end & col_end;
  assign frame_end = row_end & row_last;

  // Index registers: step chn, carry into col, carry into row, wrap at frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
      chn <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
      chn <= '0;
    end else if (en) begin
      if (!chn_end) begin
        chn <= chn + 1'b1;
      end else begin
        chn <= '0;
        if (!col_end) begin
          col <= col + 1'b1;
        end else begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/conv_pe_sched.sv
// Conv PE frame scheduler: walks row/col/chn beats, gates each row on its IFM
// line buffer, drains the PE pipeline and pulses frame_done per frame.
// Optional build macro CONV_PE_SCHED_PERF_EN adds saturating stall/wait
// cycle counters, cleared on each accepted start.
module conv_pe_sched
  import conv_pe_sched_pkg::*;
#(
  parameter int W_SIZE       = W_SIZE_DEF,
  parameter int W_CHANNEL    = W_CHANNEL_DEF,
  parameter int W_FRAME_SIZE = W_FRAME_SIZE_DEF,
  parameter int W_DELAY      = W_DELAY_DEF,
  parameter int IFM_BUF_CNT  = IFM_BUFFER_CNT,
  parameter int W_IFM_BUF    = IFM_BUFFER
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef CONV_PE_SCHED_PERF_EN
  output logic [31:0]             perf_stall_cyc,
  output logic [31:0]             perf_wait_cyc,
`endif
  input  logic                    start,
  input  logic [W_SIZE-1:0]       q_width,
  input  logic [W_SIZE-1:0]       q_height,
  input  logic [W_CHANNEL-1:0]    q_channel,
  input  logic [W_FRAME_SIZE-1:0] q_frame_cnt,
  input  logic [W_DELAY-1:0]      q_drain,
  input  logic [IFM_BUF_CNT-1:0]  ifm_buf_ready,
  input  logic                    pe_stall,
  output logic                    c_ctrl_data_run,
  output logic [W_SIZE-1:0]       c_row,
  output logic [W_SIZE-1:0]       c_col,
  output logic [W_CHANNEL-1:0]    c_chn,
  output logic [W_IFM_BUF-1:0]    c_buf_sel,
  output logic                    row_done,
  output logic [IFM_BUF_CNT-1:0]  buf_release,
  output logic                    frame_done,
  output logic                    busy
);

  sched_state_t             state, state_d;
  logic                     run_p0, run_d, accept;
  logic [W_SIZE-1:0]        col_max, row_max;
  logic [W_CHANNEL-1:0]     chn_max;
  logic [W_FRAME_SIZE-1:0]  frame_lim, frame_idx;
  logic [W_DELAY-1:0]       drain_lim, drain_cnt;
  logic [W_DELAY:0]         drain_nxt;
  logic                     drain_hit, row_end, frame_end;

  // A zero count behaves as one: the last index is then 0
  function automatic logic [W_SIZE-1:0] last_idx_size(input logic [W_SIZE-1:0] q);
    return (q == '0) ? '0 : q - 1'b1;
  endfunction

  function automatic logic [W_CHANNEL-1:0] last_idx_chn(input logic [W_CHANNEL-1:0] q);
    return (q == '0) ? '0 : q - 1'b1;
  endfunction

  conv_pe_loop_cnt #(
    .W_SIZE    (W_SIZE),
    .W_CHANNEL (W_CHANNEL)
  ) u_loop_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .en        (run_p0),
    .row_max   (row_max),
    .col_max   (col_max),
    .chn_max   (chn_max),
    .row       (c_row),
    .col       (c_col),
    .chn       (c_chn),
    .row_end   (row_end),
    .frame_end (frame_end)
  );

  // DRAIN lasts max(q_drain,1) cycles; the count is widened so it cannot wrap
  assign drain_nxt = {1'b0, drain_cnt} + 1'b1;
  assign drain_hit = (drain_nxt >= {1'b0, drain_lim});

  // Next-state and next-run decision
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    unique case (state)
      SCHED_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SCHED_WAIT_BUF;
        end
      end
      SCHED_WAIT_BUF: if (ifm_buf_ready[c_buf_sel]) state_d = SCHED_RUN;
      SCHED_RUN: begin
        if (run_p0 && row_end) state_d = frame_end ? SCHED_DRAIN : SCHED_WAIT_BUF;
      end
      SCHED_DRAIN: if (drain_hit) state_d = SCHED_DONE;
      SCHED_DONE:  state_d = (frame_idx != frame_lim) ? SCHED_WAIT_BUF : SCHED_IDLE;
      default:     state_d = SCHED_IDLE;
    endcase
    run_d = (state_d == SCHED_RUN) && !pe_stall;
  end

  // State and registered PE-valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= SCHED_IDLE;
      run_p0 <= 1'b0;
    end else begin
      state  <= state_d;
      run_p0 <= run_d;
    end
  end

  // Frame configuration captured on an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_max   <= '0;
      row_max   <= '0;
      chn_max   <= '0;
      frame_lim <= '0;
      drain_lim <= '0;
    end else if (accept) begin
      col_max   <= last_idx_size(q_width);
      row_max   <= last_idx_size(q_height);
      chn_max   <= last_idx_chn(q_channel);
      frame_lim <= q_frame_cnt;
      drain_lim <= q_drain;
    end
  end

  // Frame index within a start and drain cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_idx <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) frame_idx <= '0;
      else if (state == SCHED_DONE && frame_idx != frame_lim) frame_idx <= frame_idx + 1'b1;
      drain_cnt <= (state == SCHED_DRAIN) ? drain_nxt[W_DELAY-1:0] : '0;
    end
  end

  // Buffer select is row mod IFM_BUF_CNT (ring size is a power of two)
  assign c_buf_sel       = c_row[W_IFM_BUF-1:0];
  assign c_ctrl_data_run = run_p0;
  assign row_done        = run_p0 & row_end;
  assign buf_release     = row_done ? (IFM_BUF_CNT'(1) << c_buf_sel) : '0;
  assign frame_done      = (state == SCHED_DONE);
  assign busy            = (state != SCHED_IDLE);

`ifdef CONV_PE_SCHED_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating stall / buffer-wait cycle counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_wait_cyc  <= '0;
    end else if (accept) begin
      perf_stall_cyc <= '0;
      perf_wait_cyc  <= '0;
    end else begin
      if (state == SCHED_RUN && pe_stall) perf_stall_cyc <= sat_inc(perf_stall_cyc);
      if (state == SCHED_WAIT_BUF)        perf_wait_cyc  <= sat_inc(perf_wait_cyc);
    end
  end
`endif

endmodule

// File: tb/tb_conv_pe_sched.sv
// Directed bench for conv_pe_sched with a beat scoreboard.
module tb_conv_pe_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  q_width = 9'd1, q_height = 9'd1;
  logic [8:0]  q_channel = 9'd1;
  logic [1:0]  q_frame_cnt = 2'd0;
  logic [11:0] q_drain = 12'd0;
  logic [3:0]  ifm_buf_ready = 4'hF;
  logic        pe_stall = 1'b0;
  logic        run;
  logic [8:0]  c_row, c_col, c_chn;
  logic [1:0]  c_buf_sel;
  logic        row_done, frame_done, busy;
  logic [3:0]  buf_release;

  conv_pe_sched dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .q_width         (q_width),
    .q_height        (q_height),
    .q_channel       (q_channel),
    .q_frame_cnt     (q_frame_cnt),
    .q_drain         (q_drain),
    .ifm_buf_ready   (ifm_buf_ready),
    .pe_stall        (pe_stall),
    .c_ctrl_data_run (run),
    .c_row           (c_row),
    .c_col           (c_col),
    .c_chn           (c_chn),
    .c_buf_sel       (c_buf_sel),
    .row_done        (row_done),
    .buf_release     (buf_release),
    .frame_done      (frame_done),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] row;
    logic [8:0] col;
    logic [8:0] chn;
    logic       rd;
  } beat_t;

  beat_t sbq[$];
  int tests = 0, fails = 0;
  int cyc = 0, beats = 0, rd_cnt = 0, fd_cnt = 0, lb_cyc = 0, fd_cyc = 0;
  logic [26:0] snap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample on the falling edge and score any issued beat
  task automatic tick();
    beat_t      e;
    logic [3:0] e_rel;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      if (run) begin
        beats++;
        lb_cyc = cyc;
        if (row_done) rd_cnt++;
        check("beat_expected", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          e     = sbq.pop_front();
          e_rel = e.rd ? (4'b0001 << e.row[1:0]) : 4'b0000;
          check("beat", 64'({c_row, c_col, c_chn, row_done, buf_release, c_buf_sel}),
                64'({e.row, e.col, e.chn, e.rd, e_rel, e.row[1:0]}));
        end
      end else begin
        check("idle_pulses", 64'({row_done, buf_release}), 64'd0);
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
    end
  endtask

  task automatic push_frame(input int w, input int h, input int c);
    beat_t b;
    for (int r = 0; r < h; r++)
      for (int cl = 0; cl < w; cl++)
        for (int ch = 0; ch < c; ch++) begin
          b.row = 9'(r);
          b.col = 9'(cl);
          b.chn = 9'(ch);
          b.rd  = (cl == w - 1) && (ch == c - 1);
          sbq.push_back(b);
        end
  endtask

  task automatic do_start(input int w, input int h, input int c, input int f, input int d);
    q_width     = 9'(w);
    q_height    = 9'(h);
    q_channel   = 9'(c);
    q_frame_cnt = 2'(f);
    q_drain     = 12'(d);
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < budget);
    check("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beats < target && n < budget) begin
      tick();
      n++;
    end
    check("beats_reached", 64'(beats >= target), 64'd1);
  endtask

  task automatic wait_rows(input int target, input int budget);
    int n = 0;
    while (rd_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("rows_reached", 64'(rd_cnt >= target), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 64'({run, c_row, c_col, c_chn, c_buf_sel, row_done, buf_release, frame_done, busy}),
          64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check_all_zero("reset_outputs");
    rst = 1'b0;
    tick();

    // 1: 2x2x3 frame, drain 4
    push_frame(2, 2, 3);
    beats = 0; rd_cnt = 0; fd_cnt = 0;
    do_start(2, 2, 3, 0, 4);
    wait_idle(200);
    check("t1_beats", 64'(beats), 64'd12);
    check("t1_row_done", 64'(rd_cnt), 64'd2);
    check("t1_frame_done", 64'(fd_cnt), 64'd1);
    check("t1_drain_lat", 64'(fd_cyc - lb_cyc), 64'd5);
    check("t1_sb_empty", 64'(sbq.size()), 64'd0);

    // 2: buffer 1 not ready holds the scheduler before row 1
    ifm_buf_ready = 4'b1101;
    push_frame(2, 2, 1);
    rd_cnt = 0;
    do_start(2, 2, 1, 0, 0);
    wait_rows(1, 100);
    repeat (4) tick();
    check("t2_wait_run", 64'({run, busy}), 64'b01);
    check("t2_wait_idx", 64'({c_row, c_col, c_chn, c_buf_sel}), 64'({9'd1, 9'd0, 9'd0, 2'd1}));
    ifm_buf_ready = 4'hF;
    wait_idle(100);
    check("t2_sb_empty", 64'(sbq.size()), 64'd0);

    // 3: 3-cycle stall mid-row
    push_frame(4, 1, 2);
    beats = 0;
    do_start(4, 1, 2, 0, 1);
    wait_beats(3, 100);
    pe_stall = 1'b1;
    tick();
    check("t3_stall_run0", 64'(run), 64'd0);
    snap = {c_row, c_col, c_chn};
    tick();
    check("t3_stall_hold1", 64'({run, c_row, c_col, c_chn}), 64'({1'b0, snap}));
    tick();
    check("t3_stall_hold2", 64'({run, c_row, c_col, c_chn}), 64'({1'b0, snap}));
    pe_stall = 1'b0;
    wait_idle(100);
    check("t3_beats", 64'(beats), 64'd8);
    check("t3_sb_empty", 64'(sbq.size()), 64'd0);

    // 4: six rows exercise the buffer ring wrap
    push_frame(1, 6, 1);
    rd_cnt = 0;
    do_start(1, 6, 1, 0, 2);
    wait_idle(300);
    check("t4_row_done", 64'(rd_cnt), 64'd6);
    check("t4_sb_empty", 64'(sbq.size()), 64'd0);

    // 5: two frames per start; a second start while busy is ignored
    push_frame(1, 2, 2);
    push_frame(1, 2, 2);
    fd_cnt = 0;
    do_start(1, 2, 2, 1, 1);
    repeat (2) tick();
    q_width = 9'd3;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wait_idle(300);
    check("t5_frame_done", 64'(fd_cnt), 64'd2);
    check("t5_sb_empty", 64'(sbq.size()), 64'd0);

    // 6: reset mid-run, then a clean frame
    push_frame(3, 3, 3);
    beats = 0;
    do_start(3, 3, 3, 0, 3);
    wait_beats(5, 100);
    rst = 1'b1;
    #1;
    check_all_zero("t6_rst_outputs");
    sbq.delete();
    tick();
    rst = 1'b0;
    push_frame(2, 1, 2);
    fd_cnt = 0;
    do_start(2, 1, 2, 0, 0);
    wait_idle(100);
    check("t6_frame_done", 64'(fd_cnt), 64'd1);
    check("t6_sb_empty", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
